ofs_plat_prim_beat_packer: RTL and testbench
============================================

OFS_PLAT_PRIM_BEAT_PACKER -- requirements
Module: ofs_plat_prim_beat_packer

Interface
REQ-001 Parameter N_DATA_BITS, default 32: width of one input beat.
REQ-002 Parameter N_BEATS, default 4: beats packed per output word; SHALL be >= 2 (elaboration-time fatal otherwise).
REQ-003 Parameter FLUSH_TIMEOUT, default 16: idle cycles before a partial word is flushed; 0 disables flushing.
REQ-004 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_first  input  N_DATA_BITS  head entry of the upstream two-entry FIFO.
REQ-007 in_notEmpty  input  1  upstream FIFO holds a valid head entry.
REQ-008 in_deq_en  output  1  dequeue strobe to the upstream FIFO; in_first is consumed in the same cycle.
REQ-009 out_data  output  N_BEATS*N_DATA_BITS  packed word; beat i in bits [i*N_DATA_BITS +: N_DATA_BITS].
REQ-010 out_mask  output  N_BEATS  bit i set when beat i of out_data is valid.
REQ-011 out_count  output  $clog2(N_BEATS+1)  number of valid beats in out_data.
REQ-012 out_valid  output  1  out_data/out_mask/out_count are valid.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-014 Block SHALL hold an accumulator (N_BEATS slots, count acc_cnt in 0..N_BEATS) and one registered output word.
REQ-015 Transfer xfer SHALL be asserted when (acc_cnt == N_BEATS, or timeout_hit and acc_cnt > 0) and (!out_valid or out_ready).
REQ-016 in_deq_en SHALL equal in_notEmpty && (acc_cnt < N_BEATS || xfer); it SHALL never assert while in_notEmpty is 0.
REQ-017 in_deq_en has a combinational path from out_ready; no other input-to-output combinational paths are permitted.
REQ-018 Deq without xfer: in_first SHALL be written to slot acc_cnt and acc_cnt incremented by 1.
REQ-019 On xfer: accumulator contents SHALL load into the output register next cycle, out_valid set, out_count = acc_cnt, out_mask = low acc_cnt bits set, unused beats zero.
REQ-020 On xfer with simultaneous deq: in_first SHALL go to slot 0 and acc_cnt become 1; xfer without deq: acc_cnt becomes 0.
REQ-021 Output register: out_valid SHALL clear after a handshake unless a new xfer reloads it in the same cycle; back-to-back full words SHALL sustain one input beat per cycle.
REQ-022 out_data, out_mask and out_count SHALL remain stable while out_valid && !out_ready.
REQ-023 Idle counter SHALL increment (saturating at FLUSH_TIMEOUT) each cycle with acc_cnt > 0 and no deq; it SHALL clear on any deq, any xfer, or acc_cnt == 0.
REQ-024 timeout_hit SHALL be (FLUSH_TIMEOUT != 0) && (idle counter == FLUSH_TIMEOUT).
REQ-025 Partial flush blocked by a stalled output SHALL remain pending (counter saturated) until out_ready; a deq in the meantime clears the counter and restarts the count.
REQ-026 A full accumulator SHALL stall input (in_deq_en = 0) until xfer is possible.
REQ-027 Simulation assertion SHALL fire $fatal if out_valid drops or out_data changes before a handshake.

Reset
REQ-028 While reset is high: out_valid = 0, out_data = 0, out_mask = 0, out_count = 0, acc_cnt = 0, idle counter = 0, in_deq_en = 0.
REQ-029 Reset asserted mid-word SHALL discard all accumulated and pending output data with no partial word emitted after release.
REQ-030 First deq after reset release SHALL be permitted in the first clock edge with reset low.

Verification
REQ-031 N_BEATS=4, in_notEmpty=1 with beats 1,2,3,4, out_ready=1 -> one word {4,3,2,1}, out_mask=4'b1111, out_count=4, out_valid high exactly one cycle, 1 cycle after the 4th deq.
REQ-032 Continuous 12 beats, out_ready=1 -> 3 full words, in_deq_en high every cycle (no bubbles).
REQ-033 FLUSH_TIMEOUT=16, two beats 0xA,0xB then in_notEmpty=0 -> word {0,0,0xB,0xA}, out_mask=4'b0011, out_count=2, out_valid rises 17 cycles after last deq.
REQ-034 out_ready=0, 8 beats offered -> first word held stable, in_deq_en drops after 8th deq; out_ready=1 -> both words delivered in order, no loss or duplication.
REQ-035 Reset pulse after 3 of 4 beats -> all outputs zero; next 4 beats 5,6,7,8 -> word {8,7,6,5} only.
REQ-036 FLUSH_TIMEOUT=0, single beat then idle 1000 cycles -> out_valid never asserts.

Source files
------------

// File: rtl/ofs_plat_prim_beat_packer.sv
// Packs narrow beats from an upstream two-entry FIFO into wide output words.
// Partial words are flushed after FLUSH_TIMEOUT idle cycles (0 disables flushing).
module ofs_plat_prim_beat_packer #(
    parameter int N_DATA_BITS   = 32,
    parameter int N_BEATS       = 4,
    parameter int FLUSH_TIMEOUT = 16,
    localparam int CNT_W        = $clog2(N_BEATS + 1),
    localparam int IDLE_W       = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_DATA_BITS-1:0]         in_first,
    input  logic                           in_notEmpty,
    output logic                           in_deq_en,
    output logic [N_BEATS*N_DATA_BITS-1:0] out_data,
    output logic [N_BEATS-1:0]             out_mask,
    output logic [CNT_W-1:0]               out_count,
    output logic                           out_valid,
    input  logic                           out_ready
);

    if (N_BEATS < 2) begin : g_badBeats
        $fatal(1, "ofs_plat_prim_beat_packer: N_BEATS must be at least 2");
    end

    logic [N_DATA_BITS-1:0]         r_acc [N_BEATS];
    logic [CNT_W-1:0]               r_accCnt;
    logic [IDLE_W-1:0]              r_idleCnt;
    logic [N_BEATS*N_DATA_BITS-1:0] r_outData;
    logic [N_BEATS-1:0]             r_outMask;
    logic [CNT_W-1:0]               r_outCount;
    logic                           r_outValid;

    logic                           w_full;
    logic                           w_timeoutHit;
    logic                           w_xfer;
    logic                           w_deq;
    logic [N_BEATS*N_DATA_BITS-1:0] w_packData;
    logic [N_BEATS-1:0]             w_packMask;

    assign w_full       = (r_accCnt == CNT_W'(N_BEATS));
    assign w_timeoutHit = (FLUSH_TIMEOUT != 0) && (r_idleCnt == IDLE_W'(FLUSH_TIMEOUT));
    assign w_xfer       = (w_full || (w_timeoutHit && (r_accCnt != '0))) &&
                          (!r_outValid || out_ready);
    // Reset gating keeps the upstream FIFO untouched while the packer is held in reset.
    assign w_deq        = in_notEmpty && !reset && (!w_full || w_xfer);
    assign in_deq_en    = w_deq;

    assign out_data  = r_outData;
    assign out_mask  = r_outMask;
    assign out_count = r_outCount;
    assign out_valid = r_outValid;

    always_comb begin
        w_packData = '0;
        w_packMask = '0;
        for (int i = 0; i < N_BEATS; i++) begin
            if (CNT_W'(i) < r_accCnt) begin
                w_packData[i*N_DATA_BITS +: N_DATA_BITS] = r_acc[i];
                w_packMask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accCnt <= '0;
            for (int i = 0; i < N_BEATS; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_deq) begin
            // A beat arriving alongside a transfer starts the next word.
            if (w_xfer) begin
                r_acc[0] <= in_first;
                r_accCnt <= CNT_W'(1);
            end else begin
                for (int i = 0; i < N_BEATS; i++) begin
                    if (r_accCnt == CNT_W'(i)) begin
                        r_acc[i] <= in_first;
                    end
                end
                r_accCnt <= r_accCnt + CNT_W'(1);
            end
        end else if (w_xfer) begin
            r_accCnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idleCnt <= '0;
        end else if (w_deq || w_xfer || (r_accCnt == '0)) begin
            r_idleCnt <= '0;
        end else if ((FLUSH_TIMEOUT != 0) && (r_idleCnt != IDLE_W'(FLUSH_TIMEOUT))) begin
            r_idleCnt <= r_idleCnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outData  <= '0;
            r_outMask  <= '0;
            r_outCount <= '0;
            r_outValid <= 1'b0;
        end else if (w_xfer) begin
            r_outData  <= w_packData;
            r_outMask  <= w_packMask;
            r_outCount <= r_accCnt;
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // A held word must neither vanish nor change until the consumer takes it.
    assert property (@(posedge clk) disable iff (reset)
        (r_outValid && !out_ready) |=> (r_outValid && $stable(r_outData)))
        else $fatal(1, "ofs_plat_prim_beat_packer: output word changed before handshake");

endmodule

// File: tb/tb_ofs_plat_prim_beat_packer.sv
// Scoreboard bench for ofs_plat_prim_beat_packer: default instance (4x32, flush 16)
// plus a second instance with flushing disabled.
module tb_ofs_plat_prim_beat_packer;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   mask;
        logic [2:0]   count;
    } word_t;

    logic         clk;
    logic         reset;
    logic [31:0]  inFirst;
    logic         inNotEmpty;
    logic         inDeqEn;
    logic [127:0] outData;
    logic [3:0]   outMask;
    logic [2:0]   outCount;
    logic         outValid;
    logic         outReady;

    logic [31:0]  nfFirst;
    logic         nfNotEmpty;
    logic         nfDeqEn;
    logic [127:0] nfData;
    logic [3:0]   nfMask;
    logic [2:0]   nfCount;
    logic         nfValid;
    logic         nfReady;

    logic [31:0]  beatQ [$];
    word_t        expQ [$];

    int compareCount;
    int mismatchCount;
    int cycle;
    int deqCount;
    int bubbles;
    int handshakes;
    int validCycles;
    int riseCycle;
    int lastDeqCycle;
    int nfValidCount;
    logic [127:0] nfLastData;
    logic prevValid;

    ofs_plat_prim_beat_packer #(.N_DATA_BITS(32), .N_BEATS(4), .FLUSH_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .in_first(inFirst), .in_notEmpty(inNotEmpty),
        .in_deq_en(inDeqEn), .out_data(outData), .out_mask(outMask),
        .out_count(outCount), .out_valid(outValid), .out_ready(outReady)
    );

    ofs_plat_prim_beat_packer #(.N_DATA_BITS(32), .N_BEATS(4), .FLUSH_TIMEOUT(0)) dutNoFlush (
        .clk(clk), .reset(reset), .in_first(nfFirst), .in_notEmpty(nfNotEmpty),
        .in_deq_en(nfDeqEn), .out_data(nfData), .out_mask(nfMask),
        .out_count(nfCount), .out_valid(nfValid), .out_ready(nfReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic word_t makeWord(input logic [31:0] b0, input logic [31:0] b1,
                                       input logic [31:0] b2, input logic [31:0] b3,
                                       input int n);
        word_t w;
        logic [31:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        w.data = '0;
        w.mask = '0;
        for (int i = 0; i < n; i++) begin
            w.data[i*32 +: 32] = b[i];
            w.mask[i] = 1'b1;
        end
        w.count = 3'(n);
        return w;
    endfunction

    // Upstream FIFO model: the head is consumed on the edge following a sampled dequeue.
    initial begin
        logic takeBeat;
        inNotEmpty = 1'b0;
        inFirst    = '0;
        forever begin
            @(negedge clk);
            takeBeat = inDeqEn;
            @(posedge clk);
            #1;
            if (takeBeat && beatQ.size() > 0) void'(beatQ.pop_front());
            inNotEmpty = (beatQ.size() != 0);
            inFirst    = (beatQ.size() != 0) ? beatQ[0] : 32'h0;
        end
    end

    // Output monitor: pops the scoreboard on each handshake and keeps running tallies.
    always @(negedge clk) begin
        word_t e;
        if (outValid) validCycles++;
        if (outValid && !prevValid) riseCycle = cycle;
        prevValid = outValid;
        if (inDeqEn) begin
            deqCount++;
            lastDeqCycle = cycle + 1;
        end
        if (inNotEmpty && !inDeqEn) bubbles++;
        if (nfValid) begin
            nfValidCount++;
            nfLastData = nfData;
        end
        if (outValid && outReady) begin
            handshakes++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWord", 128'(outData), 128'(0));
            end else begin
                e = expQ.pop_front();
                checkOutput("wordData", outData, e.data);
                checkOutput("wordMask", 128'(outMask), 128'(e.mask));
                checkOutput("wordCount", 128'(outCount), 128'(e.count));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while ((expQ.size() != 0 || beatQ.size() != 0) && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0 || beatQ.size() != 0)
            checkOutput("drainTimeout", 128'(expQ.size() + beatQ.size()), 128'(0));
        #2;
    endtask

    task automatic applyStimulus(input logic [31:0] firstBeat, input int n);
        for (int i = 0; i < n; i++) beatQ.push_back(firstBeat + 32'(i));
    endtask

    initial begin
        int base0, base1, base2, base3;
        reset      = 1'b1;
        outReady   = 1'b1;
        nfNotEmpty = 1'b0;
        nfFirst    = '0;
        nfReady    = 1'b1;
        waitCycles(3);

        // Full word with reset checks and first-edge dequeue.
        applyStimulus(32'd1, 4);
        expQ.push_back(makeWord(32'd1, 32'd2, 32'd3, 32'd4, 4));
        waitCycles(2);
        @(negedge clk);
        checkOutput("rstValid", 128'(outValid), 128'(0));
        checkOutput("rstData", outData, 128'(0));
        checkOutput("rstMask", 128'(outMask), 128'(0));
        checkOutput("rstCount", 128'(outCount), 128'(0));
        checkOutput("rstDeqEn", 128'(inDeqEn), 128'(0));
        base0 = validCycles;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("deqFirstEdge", 128'(inDeqEn), 128'(1));
        waitDrain(50);
        waitCycles(3);
        checkOutput("fullLatency", 128'(riseCycle - lastDeqCycle), 128'(1));
        checkOutput("validOneCycle", 128'(validCycles - base0), 128'(1));

        // Twelve back-to-back beats with no bubbles.
        base0 = bubbles; base1 = deqCount; base2 = handshakes;
        applyStimulus(32'h100, 12);
        expQ.push_back(makeWord(32'h100, 32'h101, 32'h102, 32'h103, 4));
        expQ.push_back(makeWord(32'h104, 32'h105, 32'h106, 32'h107, 4));
        expQ.push_back(makeWord(32'h108, 32'h109, 32'h10a, 32'h10b, 4));
        waitDrain(100);
        waitCycles(3);
        checkOutput("streamBubbles", 128'(bubbles - base0), 128'(0));
        checkOutput("streamDeqs", 128'(deqCount - base1), 128'(12));
        checkOutput("streamWords", 128'(handshakes - base2), 128'(3));

        // Partial word flushed after the idle timeout.
        base2 = handshakes;
        beatQ.push_back(32'hA);
        beatQ.push_back(32'hB);
        expQ.push_back(makeWord(32'hA, 32'hB, 32'h0, 32'h0, 2));
        waitDrain(60);
        waitCycles(2);
        checkOutput("flushLatency", 128'(riseCycle - lastDeqCycle), 128'(17));
        checkOutput("flushWords", 128'(handshakes - base2), 128'(1));

        // Stalled consumer: first word held, input stalls after eight beats.
        outReady = 1'b0;
        base1 = deqCount; base2 = handshakes;
        applyStimulus(32'h11, 8);
        expQ.push_back(makeWord(32'h11, 32'h12, 32'h13, 32'h14, 4));
        expQ.push_back(makeWord(32'h15, 32'h16, 32'h17, 32'h18, 4));
        waitCycles(10);
        @(negedge clk);
        checkOutput("stallValid", 128'(outValid), 128'(1));
        checkOutput("stallData1", outData, makeWord(32'h11, 32'h12, 32'h13, 32'h14, 4).data);
        waitCycles(15);
        @(negedge clk);
        checkOutput("stallData2", outData, makeWord(32'h11, 32'h12, 32'h13, 32'h14, 4).data);
        checkOutput("stallDeqEn", 128'(inDeqEn), 128'(0));
        checkOutput("stallDeqs", 128'(deqCount - base1), 128'(8));
        checkOutput("stallNoHandshake", 128'(handshakes - base2), 128'(0));
        @(posedge clk);
        #2;
        outReady = 1'b1;
        waitDrain(30);
        waitCycles(2);
        checkOutput("stallWords", 128'(handshakes - base2), 128'(2));

        // Reset mid-word discards the partial accumulation.
        applyStimulus(32'h21, 3);
        waitCycles(8);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", 128'(outValid), 128'(0));
        checkOutput("midRstData", outData, 128'(0));
        checkOutput("midRstMask", 128'(outMask), 128'(0));
        checkOutput("midRstCount", 128'(outCount), 128'(0));
        waitCycles(2);
        reset = 1'b0;
        base2 = handshakes;
        waitCycles(25);
        checkOutput("noStaleWord", 128'(handshakes - base2), 128'(0));
        applyStimulus(32'd5, 4);
        expQ.push_back(makeWord(32'd5, 32'd6, 32'd7, 32'd8, 4));
        waitDrain(40);
        waitCycles(2);
        checkOutput("postRstWords", 128'(handshakes - base2), 128'(1));

        // Flushing disabled: a lone beat stays put until the word fills.
        base3 = nfValidCount;
        nfFirst    = 32'h55;
        nfNotEmpty = 1'b1;
        @(negedge clk);
        checkOutput("nfDeqEn", 128'(nfDeqEn), 128'(1));
        waitCycles(1);
        nfNotEmpty = 1'b0;
        waitCycles(1000);
        checkOutput("nfNoFlush", 128'(nfValidCount - base3), 128'(0));
        for (int i = 1; i < 4; i++) begin
            nfFirst    = 32'h55 + 32'(i);
            nfNotEmpty = 1'b1;
            waitCycles(1);
        end
        nfNotEmpty = 1'b0;
        waitCycles(5);
        checkOutput("nfWordCount", 128'(nfValidCount - base3), 128'(1));
        checkOutput("nfWordData", nfLastData, makeWord(32'h55, 32'h56, 32'h57, 32'h58, 4).data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
